calendar_gen: RTL and testbench

- Parametrised date keeper for the electric clock.
- Holds year/month/day as BCD and advances one day per rising edge of the clock block's day-rollover flag (full_flag).
- Supports per-field manual increment (cnt_inc), a validated parallel load, and full Gregorian leap-year handling over a configurable year range.
- Drives Data[31:0] to the display/mux stage as packed BCD YYYYMMDD.

---
 rtl/calendar_gen.sv | 208 ++++++++++++++++++++
 tb/tb_calendar_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/calendar_gen.sv
// rtl/calendar_gen.sv - BCD YYYYMMDD date keeper with day rollover, manual increment and validated load.
// Define CAL_WEEKDAY_EN to add the weekday counter; otherwise weekday is tied to zero.
module calendar_gen #(
  parameter int YEAR_MIN     = 2000,
  parameter int YEAR_MAX     = 2099,
  parameter int INIT_YEAR    = 2025,
  parameter int INIT_MONTH   = 1,
  parameter int INIT_DAY     = 1,
  parameter int INIT_WEEKDAY = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        full_flag,
  input  logic [2:0]  cnt_inc,
  input  logic        load_en,
  input  logic [31:0] load_data,
  output logic [31:0] Data,
  output logic [2:0]  weekday,
  output logic        year_wrap,
  output logic        load_err
);

  function automatic logic [15:0] to_bcd16(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] YMIN_BCD   = to_bcd16(YEAR_MIN);
  localparam logic [15:0] YMAX_BCD   = to_bcd16(YEAR_MAX);
  localparam logic [15:0] INIT_Y_BCD = to_bcd16(INIT_YEAR);
  localparam logic [7:0]  INIT_M_BCD = to_bcd8(INIT_MONTH);
  localparam logic [7:0]  INIT_D_BCD = to_bcd8(INIT_DAY);

  // Two-digit BCD value divisible by 4: even tens need ones 0/4/8, odd tens need 2/6.
  function automatic logic div4(input logic [7:0] b);
    if (b[4]) return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
    return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    return (y[7:0] == 8'h00) ? div4(y[15:8]) : div4(y[7:0]);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd_inc16(input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] d, input logic [7:0] len);
    return (d > len) ? len : d;
  endfunction

  logic [15:0] year_q, year_d;
  logic [7:0]  month_q, month_d, day_q, day_d;
  logic        wrap_q, wrap_d, err_q, err_d;
  logic        ff_prev_q;
  logic [2:0]  inc_prev_q;
  logic        day_ev, ld_ok;
  logic [2:0]  inc_ev;
  logic [7:0]  cur_len;

  assign day_ev  = full_flag & ~ff_prev_q;
  assign inc_ev  = cnt_inc & ~inc_prev_q;
  assign cur_len = month_len(month_q, is_leap(year_q));

  // BCD compares are numeric once every digit is known to be 0..9.
  assign ld_ok = digits_ok(load_data)
              && (load_data[31:16] >= YMIN_BCD) && (load_data[31:16] <= YMAX_BCD)
              && (load_data[15:8] >= 8'h01) && (load_data[15:8] <= 8'h12)
              && (load_data[7:0] >= 8'h01)
              && (load_data[7:0] <= month_len(load_data[15:8], is_leap(load_data[31:16])));

  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load_en) begin
      if (ld_ok) {year_d, month_d, day_d} = load_data;
      else       err_d = 1'b1;
    end else if (day_ev) begin
      if (day_q < cur_len) day_d = bcd_inc8(day_q);
      else begin
        day_d = 8'h01;
        if (month_q != 8'h12) month_d = bcd_inc8(month_q);
        else begin
          month_d = 8'h01;
          if (year_q == YMAX_BCD) begin
            year_d = YMIN_BCD;
            wrap_d = 1'b1;
          end else year_d = bcd_inc16(year_q);
        end
      end
    end else if (inc_ev[2]) begin
      year_d = (year_q == YMAX_BCD) ? YMIN_BCD : bcd_inc16(year_q);
      day_d  = clamp(day_q, month_len(month_q, is_leap(year_d)));
    end else if (inc_ev[1]) begin
      month_d = (month_q == 8'h12) ? 8'h01 : bcd_inc8(month_q);
      day_d   = clamp(day_q, month_len(month_d, is_leap(year_q)));
    end else if (inc_ev[0]) begin
      day_d = (day_q >= cur_len) ? 8'h01 : bcd_inc8(day_q);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      year_q     <= INIT_Y_BCD;
      month_q    <= INIT_M_BCD;
      day_q      <= INIT_D_BCD;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      ff_prev_q  <= 1'b0;
      inc_prev_q <= 3'b000;
    end else begin
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      ff_prev_q  <= full_flag;
      inc_prev_q <= cnt_inc;
    end
  end

  assign Data      = {year_q, month_q, day_q};
  assign year_wrap = wrap_q;
  assign load_err  = err_q;

`ifdef CAL_WEEKDAY_EN
  // Sakamoto form; +400 years keeps the year positive without changing the weekday.
  function automatic logic [2:0] weekday_of(input logic [15:0] y, input logic [7:0] m,
                                            input logic [7:0] d);
    int yy, mm, dd, t;
    yy = 1000 * y[15:12] + 100 * y[11:8] + 10 * y[7:4] + y[3:0] + 400;
    mm = 10 * m[7:4] + m[3:0];
    dd = 10 * d[7:4] + d[3:0];
    if (mm < 3) yy = yy - 1;
    case (mm)
      2, 6:   t = 3;
      3, 11:  t = 2;
      4, 7:   t = 5;
      8:      t = 1;
      9, 12:  t = 4;
      10:     t = 6;
      default: t = 0;
    endcase
    return 3'((yy + yy / 4 - yy / 100 + yy / 400 + t + dd) % 7);
  endfunction

  logic [2:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (load_en) begin
      if (ld_ok) wd_d = weekday_of(year_d, month_d, day_d);
    end else if (day_ev) begin
      wd_d = (wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1;
    end else if (|inc_ev) begin
      wd_d = weekday_of(year_d, month_d, day_d);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wd_q <= 3'(INIT_WEEKDAY);
    else          wd_q <= wd_d;
  end

  assign weekday = wd_q;
`else
  assign weekday = 3'(INIT_WEEKDAY) & 3'd0;
`endif

endmodule

// File: tb/tb_calendar_gen.sv
// tb/tb_calendar_gen.sv - directed self-checking bench for calendar_gen (default and YEAR_MAX=2199 instances).
module tb_calendar_gen;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        full_flag = 1'b0;
  logic [2:0]  cnt_inc = 3'b000;
  logic        load_en = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic [31:0] data_a, data_b;
  logic [2:0]  wd_a, wd_b;
  logic        wrap_a, wrap_b, err_a, err_b;
  int          tests = 0;
  int          fails = 0;

`ifdef CAL_WEEKDAY_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  always #10 Clk = ~Clk;

  calendar_gen dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .full_flag(full_flag), .cnt_inc(cnt_inc),
    .load_en(load_en), .load_data(load_data), .Data(data_a), .weekday(wd_a),
    .year_wrap(wrap_a), .load_err(err_a)
  );

  calendar_gen #(.YEAR_MAX(2199)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .full_flag(full_flag), .cnt_inc(cnt_inc),
    .load_en(load_en), .load_data(load_data), .Data(data_b), .weekday(wd_b),
    .year_wrap(wrap_b), .load_err(err_b)
  );

  task automatic pulse_day();
    @(negedge Clk) full_flag = 1'b1;
    @(negedge Clk) full_flag = 1'b0;
  endtask

  task automatic pulse_inc(input int b);
    @(negedge Clk) cnt_inc = 3'b001 << b;
    @(negedge Clk) cnt_inc = 3'b000;
  endtask

  task automatic do_load(input logic [31:0] d);
    @(negedge Clk) begin load_en = 1'b1; load_data = d; end
    @(negedge Clk) load_en = 1'b0;
  endtask

  task automatic test_reset();
    #100;
    tests++; if (data_a !== 32'h20250101) begin fails++; $display("FAIL reset_data got %h want 20250101", data_a); end
    tests++; if (wd_a !== (WD_EN ? 3'd3 : 3'd0)) begin fails++; $display("FAIL reset_weekday got %0d want %0d", wd_a, WD_EN ? 3 : 0); end
    tests++; if (wrap_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL reset_pulses got wrap=%b err=%b want 0 0", wrap_a, err_a); end
    #101 Reset_n = 1'b1;
  endtask

  task automatic test_hold_level();
    @(negedge Clk) full_flag = 1'b1;
    @(negedge Clk);
    tests++; if (data_a !== 32'h20250102) begin fails++; $display("FAIL hold_first got %h want 20250102", data_a); end
    repeat (1999) @(negedge Clk);
    tests++; if (data_a !== 32'h20250102) begin fails++; $display("FAIL hold_once got %h want 20250102", data_a); end
    tests++; if (wd_a !== (WD_EN ? 3'd4 : 3'd0)) begin fails++; $display("FAIL hold_weekday got %0d want %0d", wd_a, WD_EN ? 4 : 0); end
    full_flag = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_leap();
    do_load(32'h20240228);
    tests++; if (data_a !== 32'h20240228 || err_a !== 1'b0) begin fails++; $display("FAIL leap_load got %h err=%b want 20240228 err=0", data_a, err_a); end
    pulse_day();
    tests++; if (data_a !== 32'h20240229) begin fails++; $display("FAIL leap_feb29 got %h want 20240229", data_a); end
    pulse_day();
    tests++; if (data_a !== 32'h20240301) begin fails++; $display("FAIL leap_mar01 got %h want 20240301", data_a); end
  endtask

  task automatic test_century();
    do_load(32'h21000228);
    tests++; if (data_b !== 32'h21000228) begin fails++; $display("FAIL c2100_load got %h want 21000228", data_b); end
    tests++; if (err_a !== 1'b1 || data_a !== 32'h20240301) begin fails++; $display("FAIL c2100_range got %h err=%b want 20240301 err=1", data_a, err_a); end
    pulse_day();
    tests++; if (data_b !== 32'h21000301) begin fails++; $display("FAIL c2100_noleap got %h want 21000301", data_b); end
    do_load(32'h20000228);
    pulse_day();
    tests++; if (data_a !== 32'h20000229) begin fails++; $display("FAIL c2000_feb29 got %h want 20000229", data_a); end
    pulse_day();
    tests++; if (data_a !== 32'h20000301) begin fails++; $display("FAIL c2000_mar01 got %h want 20000301", data_a); end
  endtask

  task automatic test_year_wrap();
    do_load(32'h20991231);
    tests++; if (wd_a !== (WD_EN ? 3'd4 : 3'd0)) begin fails++; $display("FAIL wrap_load_weekday got %0d want %0d", wd_a, WD_EN ? 4 : 0); end
    pulse_day();
    tests++; if (data_a !== 32'h20000101 || wrap_a !== 1'b1) begin fails++; $display("FAIL wrap_rollover got %h wrap=%b want 20000101 wrap=1", data_a, wrap_a); end
    tests++; if (data_b !== 32'h21000101 || wrap_b !== 1'b0) begin fails++; $display("FAIL wrap_wide got %h wrap=%b want 21000101 wrap=0", data_b, wrap_b); end
    tests++; if (wd_a !== (WD_EN ? 3'd5 : 3'd0)) begin fails++; $display("FAIL wrap_weekday got %0d want %0d", wd_a, WD_EN ? 5 : 0); end
    @(negedge Clk);
    tests++; if (wrap_a !== 1'b0) begin fails++; $display("FAIL wrap_one_cycle got %b want 0", wrap_a); end
  endtask

  task automatic test_manual_inc();
    do_load(32'h20250131);
    pulse_inc(1);
    tests++; if (data_a !== 32'h20250228) begin fails++; $display("FAIL inc_month_clamp got %h want 20250228", data_a); end
    tests++; if (wd_a !== (WD_EN ? 3'd5 : 3'd0)) begin fails++; $display("FAIL inc_month_weekday got %0d want %0d", wd_a, WD_EN ? 5 : 0); end
    pulse_inc(0);
    tests++; if (data_a !== 32'h20250201) begin fails++; $display("FAIL inc_day_wrap got %h want 20250201", data_a); end
    pulse_inc(2);
    tests++; if (data_a !== 32'h20260201) begin fails++; $display("FAIL inc_year got %h want 20260201", data_a); end
    do_load(32'h20990615);
    pulse_inc(2);
    tests++; if (data_a !== 32'h20000615 || wrap_a !== 1'b0) begin fails++; $display("FAIL inc_year_wrap got %h wrap=%b want 20000615 wrap=0", data_a, wrap_a); end
    @(negedge Clk) cnt_inc = 3'b111;
    @(negedge Clk) cnt_inc = 3'b000;
    tests++; if (data_a !== 32'h20010615) begin fails++; $display("FAIL inc_priority got %h want 20010615", data_a); end
  endtask

  task automatic test_load_err();
    do_load(32'h20251331);
    tests++; if (err_a !== 1'b1 || data_a !== 32'h20010615) begin fails++; $display("FAIL err_month got %h err=%b want 20010615 err=1", data_a, err_a); end
    @(negedge Clk);
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL err_one_cycle got %b want 0", err_a); end
    do_load(32'h2025021A);
    tests++; if (err_a !== 1'b1 || data_a !== 32'h20010615) begin fails++; $display("FAIL err_digit got %h err=%b want 20010615 err=1", data_a, err_a); end
    do_load(32'h20250229);
    tests++; if (err_a !== 1'b1 || data_a !== 32'h20010615) begin fails++; $display("FAIL err_feb29 got %h err=%b want 20010615 err=1", data_a, err_a); end
  endtask

  task automatic test_priority();
    @(negedge Clk) begin load_en = 1'b1; load_data = 32'h20250615; full_flag = 1'b1; end
    @(negedge Clk) begin load_en = 1'b0; full_flag = 1'b0; end
    tests++; if (data_a !== 32'h20250615) begin fails++; $display("FAIL prio_load got %h want 20250615", data_a); end
    @(negedge Clk);
    tests++; if (data_a !== 32'h20250615) begin fails++; $display("FAIL prio_no_queue got %h want 20250615", data_a); end
    @(negedge Clk) begin full_flag = 1'b1; cnt_inc = 3'b100; end
    @(negedge Clk) begin full_flag = 1'b0; cnt_inc = 3'b000; end
    tests++; if (data_a !== 32'h20250616) begin fails++; $display("FAIL prio_day_over_inc got %h want 20250616", data_a); end
    @(negedge Clk);
    tests++; if (data_a !== 32'h20250616) begin fails++; $display("FAIL prio_inc_dropped got %h want 20250616", data_a); end
  endtask

  initial begin
    test_reset();
    test_hold_level();
    test_leap();
    test_century();
    test_year_wrap();
    test_manual_inc();
    test_load_err();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
